// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the core's memory-side arbitration logic.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Owner encoding, also the value driven on o_grant_dcache.
    localparam logic OWNER_ICACHE = 1'b0;
    localparam logic OWNER_DCACHE = 1'b1;

endpackage

// File: rtl/riscv_core_rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the side
// that did not own the previous fill.
module riscv_core_rr_arbiter2
    import riscv_core_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    // Pure combinational selection; the caller decides when to act on it.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWNER_ICACHE;
        if (req_i && req_d) begin
            grant_owner = (last_owner == OWNER_DCACHE) ? OWNER_ICACHE : OWNER_DCACHE;
        end else if (req_d) begin
            grant_owner = OWNER_DCACHE;
        end
    end

endmodule

// File: rtl/riscv_core_mem_read_arbiter.sv
// Shares the AXI block-fill read channel between icache and dcache.
// One fill at a time: IDLE picks an owner, BUSY holds the request to the AXI
// master, RESP presents the registered block and pulses the owner's done.
module riscv_core_mem_read_arbiter
    import riscv_core_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_icache_read_req,
    input  logic [ADDR_WIDTH-1:0]     i_icache_read_address,
    output logic                      o_icache_read_done,
    output logic [AXI_DATA_WIDTH-1:0] o_icache_block,
    input  logic                      i_dcache_read_req,
    input  logic [ADDR_WIDTH-1:0]     i_dcache_read_address,
    output logic                      o_dcache_read_done,
    output logic [AXI_DATA_WIDTH-1:0] o_dcache_block,
    output logic                      o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]     o_mem_read_address,
    input  logic                      i_mem_read_done,
    input  logic [AXI_DATA_WIDTH-1:0] i_block_from_axi,
    output logic                      o_busy,
    output logic                      o_grant_dcache
);

    arb_state_e                state;
    arb_state_e                state_nxt;
    logic                      owner;
    logic                      last_owner;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0] block_q;
    logic                      grant_valid;
    logic                      grant_owner;

    riscv_core_rr_arbiter2 u_rr (
        .req_i       (i_icache_read_req),
        .req_d       (i_dcache_read_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next-state logic; done pulses outside BUSY fall through untouched.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = BUSY;
            BUSY:    if (i_mem_read_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant bookkeeping and the latched address/block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= OWNER_ICACHE;
            last_owner <= OWNER_DCACHE;
            addr_q     <= '0;
            block_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_valid) begin
                owner  <= grant_owner;
                addr_q <= (grant_owner == OWNER_DCACHE) ? i_dcache_read_address
                                                        : i_icache_read_address;
            end
            if (state == BUSY && i_mem_read_done) block_q <= i_block_from_axi;
            if (state == RESP) last_owner <= owner;
        end
    end

    // Outputs decode from registered state only, so requesters see no
    // combinational path from the AXI side.
    always_comb begin
        o_mem_read_req     = (state == BUSY);
        o_mem_read_address = (state == BUSY) ? addr_q : '0;
        o_busy             = (state == BUSY) || (state == RESP);
        o_icache_read_done = (state == RESP) && (owner == OWNER_ICACHE);
        o_dcache_read_done = (state == RESP) && (owner == OWNER_DCACHE);
        o_icache_block     = block_q;
        o_dcache_block     = block_q;
        o_grant_dcache     = owner;
    end

endmodule
